// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a big-endian byte stream into 32-bit words
// and writes them to consecutive word addresses while holding the CPU in reset.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         word_q, word_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     written_q, written_d;
    logic                error_q, error_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;

    logic                start_ok;
    logic [ADDR_W:0]     written_inc;
    logic [31:0]         word_shifted;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        count_d      = count_q;
        written_d    = written_q;
        error_d      = error_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        start_ok     = start && (word_count != '0) && (word_count <= DEPTH_L);
        written_inc  = written_q + 1'b1;
        word_shifted = {word_q[23:0], byte_in};

        case (state_q)
            IDLE, DONE: begin
                // A rejected start only raises error; state, done and cpu_hold stay put.
                if (start) begin
                    if (start_ok) begin
                        state_d    = LOAD;
                        error_d    = 1'b0;
                        addr_d     = '0;
                        byte_cnt_d = '0;
                        word_d     = '0;
                        written_d  = '0;
                        count_d    = word_count;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (byte_valid) begin
                    word_d     = word_shifted;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d   = WRITE;
                        wr_addr_d = addr_q;
                        wr_data_d = word_shifted;
                    end
                end
            end
            WRITE: begin
                addr_d    = addr_q + 1'b1;
                written_d = written_inc;
                state_d   = (written_inc == count_q) ? DONE : LOAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            count_q    <= '0;
            written_q  <= '0;
            error_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            count_q    <= count_d;
            written_q  <= written_d;
            error_q    <= error_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign byte_ready = (state_q == LOAD);
    assign wr_en      = (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign cpu_hold   = (state_q != DONE);
    assign error      = error_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: the driver queues each expected memory write,
// and a negedge monitor pops and compares whenever wr_en is seen.
module tb_imem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t               exp_q[$];
    wr_t               mon_item;
    int                checks = 0;
    int                errors = 0;
    logic              rst_at_edge = 1'b0;
    logic              synced = 1'b0;
    logic [ADDR_W-1:0] hold_addr = '0;
    logic [31:0]       hold_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest queued expectation; otherwise outputs hold.
    always @(posedge clk) rst_at_edge <= rst;

    always @(negedge clk) begin
        if (rst_at_edge) begin
            synced    = 1'b1;
            hold_addr = '0;
            hold_data = '0;
        end
        if (synced) begin
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                             wr_addr, wr_data);
                end else begin
                    mon_item = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(mon_item.addr));
                    check("wr_data", wr_data, mon_item.data);
                    hold_addr = mon_item.addr;
                    hold_data = mon_item.data;
                end
            end else begin
                check("wr_en_x", 32'(wr_en), 32'd0);
                check("hold_addr", 32'(wr_addr), 32'(hold_addr));
                check("hold_data", wr_data, hold_data);
            end
        end
    end

    // All driver tasks begin and end just after a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start(input int wc);
        start      = 1'b1;
        word_count = (ADDR_W + 1)'(wc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        t = 0;
        while (byte_ready !== 1'b1 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) begin
            checks++;
            errors++;
            $display("[TB] FAIL byte_timeout: got byte_ready=%b expected 1 within 64 cycles", byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // The first byte sent is the most significant one of the word.
    task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                             input int gap, input bit last, input bit poke_start);
        exp_q.push_back('{addr: addr, data: data});
        for (int i = 0; i < 4; i++) begin
            if (poke_start && i == 2) begin
                start      = 1'b1;
                word_count = (ADDR_W + 1)'(1);
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(data[31-8*i -: 8], gap);
        end
        check("write_latency", 32'(wr_en), 32'd1);
        check("ready_in_write", 32'(byte_ready), 32'd0);
        if (!last) begin
            byte_valid = 1'b1;
            byte_in    = 8'hEE;
        end
        if (poke_start) begin
            start      = 1'b1;
            word_count = (ADDR_W + 1)'(1);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
        check("single_strobe", 32'(wr_en), 32'd0);
        check("done_after_write", 32'(done), last ? 32'd1 : 32'd0);
        check("hold_after_write", 32'(cpu_hold), last ? 32'd0 : 32'd1);
    endtask

    task automatic load(input int wc, input int gap, input bit poke);
        logic [7:0]  b[4];
        logic [31:0] data;
        pulse_start(wc);
        check("start_error", 32'(error), 32'd0);
        check("start_ready", 32'(byte_ready), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_hold", 32'(cpu_hold), 32'd1);
        for (int w = 0; w < wc; w++) begin
            for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
            data = (32'(b[0]) << 24) | (32'(b[1]) << 16) | (32'(b[2]) << 8) | 32'(b[3]);
            send_word(ADDR_W'(w), data, gap, w == wc - 1, poke && w == 0);
        end
    endtask

    task automatic check_rejected(input string name, input bit was_done);
        check({name, "_error"}, 32'(error), 32'd1);
        check({name, "_ready"}, 32'(byte_ready), 32'd0);
        check({name, "_done"}, 32'(done), was_done ? 32'd1 : 32'd0);
        check({name, "_hold"}, 32'(cpu_hold), was_done ? 32'd0 : 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        word_count = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", 32'(byte_ready), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_hold", 32'(cpu_hold), 32'd1);
        check("reset_error", 32'(error), 32'd0);
        check("reset_wr_en", 32'(wr_en), 32'd0);
        check("reset_wr_addr", 32'(wr_addr), 32'd0);
        check("reset_wr_data", wr_data, 32'd0);

        $display("[TB] basic load");
        pulse_start(2);
        send_word(ADDR_W'(0), 32'h2010000A, 0, 1'b0, 1'b0);
        send_word(ADDR_W'(1), 32'h20110019, 0, 1'b1, 1'b0);

        $display("[TB] stalled load");
        pulse_start(2);
        send_word(ADDR_W'(0), 32'h2010000A, 3, 1'b0, 1'b0);
        send_word(ADDR_W'(1), 32'h20110019, 3, 1'b1, 1'b0);

        $display("[TB] bounds");
        do_reset();
        pulse_start(0);
        check_rejected("wc0", 1'b0);
        pulse_start(DEPTH + 1);
        check_rejected("wc65", 1'b0);
        load(DEPTH, 0, 1'b0);
        pulse_start(0);
        check_rejected("done_wc0", 1'b1);

        $display("[TB] reset mid-word");
        pulse_start(2);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        do_reset();
        check("midrst_ready", 32'(byte_ready), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        load(1, 0, 1'b0);

        $display("[TB] start ignored and reload");
        load(3, 1, 1'b1);
        load(1, 0, 1'b0);

        $display("[TB] simultaneous reset and start");
        pulse_start(0);
        check("pre_sim_error", 32'(error), 32'd1);
        rst        = 1'b1;
        start      = 1'b1;
        word_count = (ADDR_W + 1)'(3);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("sim_error", 32'(error), 32'd0);
        check("sim_ready", 32'(byte_ready), 32'd0);
        check("sim_done", 32'(done), 32'd0);
        check("sim_hold", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        check("sim_still_idle", 32'(byte_ready), 32'd0);

        $display("[TB] randomized sessions");
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                pulse_start($urandom_range(0, 1) == 0 ? 0 : $urandom_range(DEPTH + 1, 2 * DEPTH - 1));
                check("rand_reject", 32'(error), 32'd1);
            end
            if ($urandom_range(0, 5) == 0) do_reset();
            load($urandom_range(1, 8), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, giving the instruction memory depth in 32-bit words.
REQ-002 The module SHALL have parameter ADDR_W, default 6, giving the word-address width (log2 DEPTH).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 word_count  input  ADDR_W+1  number of words to load, sampled on the accepted start.
REQ-007 byte_in  input  8  instruction byte stream data.
REQ-008 byte_valid  input  1  byte_in holds a valid byte.
REQ-009 byte_ready  output  1  the loader accepts a byte this cycle.
REQ-010 wr_en  output  1  one-cycle write strobe to the instruction memory.
REQ-011 wr_addr  output  ADDR_W  word address of the write (byte address = wr_addr<<2).
REQ-012 wr_data  output  32  instruction word to be written.
REQ-013 cpu_hold  output  1  holds the pipeline/PC in reset while memory contents are invalid.
REQ-014 done  output  1  load session complete.
REQ-015 error  output  1  sticky flag indicating that the last start was rejected.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, WRITE, DONE.
REQ-017 A byte SHALL be transferred only on a cycle with byte_valid=1 and byte_ready=1.
REQ-018 byte_ready SHALL be 1 only in LOAD; it is 0 in IDLE, WRITE and DONE.
REQ-019 In IDLE or DONE, start=1 with 1<=word_count<=DEPTH SHALL clear error and done, clear addr and the byte counter, latch word_count, and move to LOAD on the next cycle.
REQ-020 In IDLE or DONE, start=1 with word_count=0 or word_count>DEPTH SHALL set error=1 and leave the state, done and cpu_hold unchanged.
REQ-021 start SHALL be ignored in LOAD and WRITE.
REQ-022 Bytes SHALL assemble big-endian: the 1st byte goes to [31:24], the 2nd to [23:16], the 3rd to [15:8] and the 4th to [7:0].
REQ-023 The accepted 4th byte SHALL move the FSM to WRITE; in WRITE, wr_en=1 for exactly one cycle, with wr_addr equal to the current addr and wr_data equal to the assembled word.
REQ-024 wr_en SHALL be 0 in all other states and cycles.
REQ-025 After WRITE, addr SHALL increment by 1 (modulo 2^ADDR_W).
REQ-026 After WRITE, the FSM SHALL go to DONE if the written count equals the latched word_count, and otherwise to LOAD.
REQ-027 The latency from acceptance of the 4th byte to wr_en SHALL be 1 cycle.
REQ-028 The minimum spacing between writes SHALL be 5 cycles (4 byte cycles plus 1 WRITE cycle).
REQ-029 byte_valid gaps in LOAD SHALL stall assembly without losing a partial word.
REQ-030 In DONE, done SHALL be 1 and cpu_hold SHALL be 0; in every other state, cpu_hold SHALL be 1 and done SHALL be 0.
REQ-031 wr_data and wr_addr SHALL hold their last values when wr_en=0.
REQ-032 A load SHALL write addresses 0..word_count-1 only; words beyond that range are left untouched.

Reset
REQ-033 When rst=1 at a clock edge, the FSM SHALL go to IDLE, from any state including mid-word or during WRITE.
REQ-034 On that reset edge, the block SHALL clear addr, the byte counter and the assembled word.
REQ-035 On that reset edge, the block SHALL set wr_en=0, byte_ready=0, done=0, error=0, cpu_hold=1, wr_addr=0 and wr_data=0.
REQ-036 rst SHALL take priority over start and byte_valid in the same cycle.
REQ-037 A partial word present at reset SHALL be discarded, and no write SHALL occur.

Verification
REQ-038 Scenario 1 (basic load): start with word_count=2, then bytes 20,10,00,0A and 20,11,00,19 with no gaps -> wr_en at addr 0 with data 0x2010000A, then at addr 1 with data 0x20110019; done=1 and cpu_hold=0 one cycle after the second WRITE.
REQ-039 Scenario 2 (stalls): same as scenario 1 with byte_valid low for 3 cycles between every byte -> same writes, with no extra or missing wr_en pulses.
REQ-040 Scenario 3 (bounds): start with word_count=0 -> error=1 and the FSM stays in IDLE; start with word_count=65 -> error=1; start with word_count=64 and 256 bytes -> 64 writes to addresses 0..63, then done.
REQ-041 Scenario 4 (reset mid-word): rst after 2 bytes of word 1 -> IDLE, cpu_hold=1, no wr_en; then a fresh start with word_count=1 -> write at addr 0.
REQ-042 Scenario 5 (start ignored / reload): start pulses during LOAD have no effect; a start in DONE with word_count=1 -> done=0, cpu_hold=1, and the next write goes to addr 0.
REQ-043 Scenario 6 (simultaneous events): rst and start together -> IDLE with error=0; byte_valid held high in WRITE -> the byte is not consumed (byte_ready=0).
